// File: rtl/butterfly_xbar_in_pipe.sv
// Butterfly operand crossbar: routes two read-port word vectors into
// top/bottom operand pairs per stride, behind an output register plus skid.
module butterfly_xbar_in_pipe #(
    parameter int DATA_W   = 32,
    parameter int LANES    = 4,
    parameter int STRIDE_W = 10,
    parameter int TAG_W    = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      i_VALID,
    output logic                      o_READY,
    input  logic [STRIDE_W-1:0]       i_STRIDE,
    input  logic [LANES*DATA_W-1:0]   i_READ_OUTPUT1,
    input  logic [LANES*DATA_W-1:0]   i_READ_OUTPUT2,
    input  logic [TAG_W-1:0]          i_TAG,
    input  logic                      i_CNT_CLR,
    output logic                      o_VALID,
    input  logic                      i_READY,
    output logic [LANES*DATA_W-1:0]   o_BUTTERFLY_TOP,
    output logic [LANES*DATA_W-1:0]   o_BUTTERFLY_BOTTOM,
    output logic [TAG_W-1:0]          o_TAG,
    output logic                      o_STRIDE_ERR,
    output logic [15:0]               o_BEAT_CNT
);

    localparam int LG    = $clog2(LANES);
    localparam int BUS_W = LANES * DATA_W;
    localparam logic [STRIDE_W-1:0] LANES_S = STRIDE_W'(LANES);

    typedef struct packed {
        logic [BUS_W-1:0] top;
        logic [BUS_W-1:0] bot;
        logic [TAG_W-1:0] tag;
        logic             err;
    } beat_t;

    logic [DATA_W-1:0] words [2*LANES];
    logic [BUS_W-1:0]  cand_top [LG+1];
    logic [BUS_W-1:0]  cand_bot [LG+1];
    logic [LG:0]       hit;
    logic              legal;
    logic              big;
    logic [BUS_W-1:0]  route_top;
    logic [BUS_W-1:0]  route_bot;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            words[k]       = i_READ_OUTPUT1[k*DATA_W +: DATA_W];
            words[LANES+k] = i_READ_OUTPUT2[k*DATA_W +: DATA_W];
        end
    end

    assign legal = (i_STRIDE != '0) &&
                   ((i_STRIDE & (i_STRIDE - 1'b1)) == '0);
    assign big   = (i_STRIDE >= LANES_S);

    // One fixed wiring pattern per effective stride 1, 2, 4 .. LANES.
    for (genvar k = 0; k <= LG; k++) begin : g_s
        localparam int S = 1 << k;
        if (k == LG) begin : g_big
            assign hit[k] = big;
        end else begin : g_small
            assign hit[k] = (i_STRIDE == STRIDE_W'(S));
        end
        for (genvar p = 0; p < LANES; p++) begin : g_p
            localparam int IT = 2 * S * (p / S) + (p % S);
            assign cand_top[k][p*DATA_W +: DATA_W] = words[IT];
            assign cand_bot[k][p*DATA_W +: DATA_W] = words[IT+S];
        end
    end

    always_comb begin
        route_top = '0;
        route_bot = '0;
        for (int k = 0; k <= LG; k++) begin
            if (legal && hit[k]) begin
                route_top = cand_top[k];
                route_bot = cand_bot[k];
            end
        end
    end

    beat_t in_beat;
    beat_t out_q, out_n;
    beat_t skid_q, skid_n;
    logic  out_valid_q, out_valid_n;
    logic  skid_valid_q, skid_valid_n;
    logic  ready_q;
    logic  accept;
    logic  fire;
    logic [15:0] cnt_q;

    assign in_beat = '{top: route_top, bot: route_bot,
                       tag: i_TAG, err: !legal};

    assign accept = i_VALID && ready_q;
    assign fire   = out_valid_q && i_READY;

    always_comb begin
        out_n        = out_q;
        skid_n       = skid_q;
        out_valid_n  = out_valid_q;
        skid_valid_n = skid_valid_q;
        if (skid_valid_q) begin
            if (fire) begin
                out_n        = skid_q;
                skid_valid_n = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || fire) begin
                out_n       = in_beat;
                out_valid_n = 1'b1;
            end else begin
                skid_n       = in_beat;
                skid_valid_n = 1'b1;
            end
        end else if (fire) begin
            out_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_q        <= out_n;
            skid_q       <= skid_n;
            out_valid_q  <= out_valid_n;
            skid_valid_q <= skid_valid_n;
            ready_q      <= !skid_valid_n;
        end
    end

    // Clear wins over a coincident accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (i_CNT_CLR) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign o_READY            = ready_q;
    assign o_VALID            = out_valid_q;
    assign o_BUTTERFLY_TOP    = out_q.top;
    assign o_BUTTERFLY_BOTTOM = out_q.bot;
    assign o_TAG              = out_q.tag;
    assign o_STRIDE_ERR       = out_q.err;
    assign o_BEAT_CNT         = cnt_q;

endmodule

// File: tb/tb_butterfly_xbar_in_pipe.sv
// Self-checking bench for butterfly_xbar_in_pipe: directed vector table,
// randomized traffic against a queue model, and multi-cycle corner cases.
module tb_butterfly_xbar_in_pipe;

    localparam int DW = 32;
    localparam int LN = 4;
    localparam int SW = 10;
    localparam int TW = 8;
    localparam int BW = LN * DW;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          i_VALID = 1'b0;
    logic          o_READY;
    logic [SW-1:0] i_STRIDE = '0;
    logic [BW-1:0] i_READ_OUTPUT1 = '0;
    logic [BW-1:0] i_READ_OUTPUT2 = '0;
    logic [TW-1:0] i_TAG = '0;
    logic          i_CNT_CLR = 1'b0;
    logic          o_VALID;
    logic          i_READY = 1'b1;
    logic [BW-1:0] o_BUTTERFLY_TOP;
    logic [BW-1:0] o_BUTTERFLY_BOTTOM;
    logic [TW-1:0] o_TAG;
    logic          o_STRIDE_ERR;
    logic [15:0]   o_BEAT_CNT;

    butterfly_xbar_in_pipe #(
        .DATA_W(DW), .LANES(LN), .STRIDE_W(SW), .TAG_W(TW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .i_VALID(i_VALID),
        .o_READY(o_READY),
        .i_STRIDE(i_STRIDE),
        .i_READ_OUTPUT1(i_READ_OUTPUT1),
        .i_READ_OUTPUT2(i_READ_OUTPUT2),
        .i_TAG(i_TAG),
        .i_CNT_CLR(i_CNT_CLR),
        .o_VALID(o_VALID),
        .i_READY(i_READY),
        .o_BUTTERFLY_TOP(o_BUTTERFLY_TOP),
        .o_BUTTERFLY_BOTTOM(o_BUTTERFLY_BOTTOM),
        .o_TAG(o_TAG),
        .o_STRIDE_ERR(o_STRIDE_ERR),
        .o_BEAT_CNT(o_BEAT_CNT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] top;
        logic [BW-1:0] bot;
        logic [TW-1:0] tag;
        logic          err;
    } beat_t;

    typedef struct {
        logic [SW-1:0] stride;
        logic [TW-1:0] tag;
        logic [BW-1:0] top;
        logic [BW-1:0] bot;
        logic          err;
    } vec_t;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference routing straight from the stride rule.
    function automatic beat_t model(logic [SW-1:0] st, logic [BW-1:0] r1,
                                    logic [BW-1:0] r2, logic [TW-1:0] tg);
        beat_t b;
        logic [DW-1:0] w [2*LN];
        int s;
        int ix;
        b.tag = tg;
        b.top = '0;
        b.bot = '0;
        b.err = !((st != 0) && ($countones(st) == 1));
        for (int k = 0; k < LN; k++) begin
            w[k]    = r1[k*DW +: DW];
            w[k+LN] = r2[k*DW +: DW];
        end
        if (!b.err) begin
            s = (st >= LN) ? LN : int'(st);
            for (int p = 0; p < LN; p++) begin
                ix = 2 * s * (p / s) + (p % s);
                b.top[p*DW +: DW] = w[ix];
                b.bot[p*DW +: DW] = w[ix+s];
            end
        end
        return b;
    endfunction

    task automatic do_reset();
        resetn    = 1'b0;
        i_VALID   = 1'b0;
        i_READY   = 1'b1;
        i_CNT_CLR = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    localparam logic [BW-1:0] R1 =
        {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [BW-1:0] R2 =
        {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    localparam logic [BW-1:0] T2 =
        {32'hBBBBBBBB, 32'hAAAAAAAA, 32'h22222222, 32'h11111111};
    localparam logic [BW-1:0] B2 =
        {32'hDDDDDDDD, 32'hCCCCCCCC, 32'h44444444, 32'h33333333};
    localparam logic [BW-1:0] T1 =
        {32'hCCCCCCCC, 32'hAAAAAAAA, 32'h33333333, 32'h11111111};
    localparam logic [BW-1:0] B1 =
        {32'hDDDDDDDD, 32'hBBBBBBBB, 32'h44444444, 32'h22222222};

    vec_t  tbl [8];
    beat_t q [$];
    beat_t nb;
    logic [15:0] mcnt;
    logic  acc;
    logic  fire;
    logic [TW-1:0] got [$];
    logic [TW-1:0] cur_tag;
    int    next_tag;
    int    stall;
    logic  first_seen;
    logic  dropped;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{stride: 10'd8,   tag: 8'h01, top: R1, bot: R2, err: 1'b0};
        tbl[1] = '{stride: 10'd2,   tag: 8'h02, top: T2, bot: B2, err: 1'b0};
        tbl[2] = '{stride: 10'd1,   tag: 8'h03, top: T1, bot: B1, err: 1'b0};
        tbl[3] = '{stride: 10'd4,   tag: 8'h04, top: R1, bot: R2, err: 1'b0};
        tbl[4] = '{stride: 10'd0,   tag: 8'h5A, top: '0, bot: '0, err: 1'b1};
        tbl[5] = '{stride: 10'd3,   tag: 8'hA5, top: '0, bot: '0, err: 1'b1};
        tbl[6] = '{stride: 10'd512, tag: 8'h07, top: R1, bot: R2, err: 1'b0};
        tbl[7] = '{stride: 10'd2,   tag: 8'h08, top: T2, bot: B2, err: 1'b0};

        #1 resetn = 1'b0;
        #1;
        chk("rst_valid", o_VALID, 1'b0);
        chk("rst_ready", o_READY, 1'b0);
        chk("rst_cnt", o_BEAT_CNT, 16'h0);
        chk("rst_err", o_STRIDE_ERR, 1'b0);
        chk("rst_top", o_BUTTERFLY_TOP, '0);
        chk("rst_tag", o_TAG, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_ready", o_READY, 1'b0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_exit_ready", o_READY, 1'b1);

        i_READ_OUTPUT1 = R1;
        i_READ_OUTPUT2 = R2;
        for (int i = 0; i < 8; i++) begin
            i_VALID  = 1'b1;
            i_STRIDE = tbl[i].stride;
            i_TAG    = tbl[i].tag;
            @(posedge clk);
            #1;
            i_VALID = 1'b0;
            chk("tbl_valid", o_VALID, 1'b1);
            chk("tbl_top", o_BUTTERFLY_TOP, tbl[i].top);
            chk("tbl_bot", o_BUTTERFLY_BOTTOM, tbl[i].bot);
            chk("tbl_err", o_STRIDE_ERR, tbl[i].err);
            chk("tbl_tag", o_TAG, tbl[i].tag);
            chk("tbl_cnt", o_BEAT_CNT, 16'(i + 1));
        end
        @(posedge clk);
        #1;
        chk("tbl_drain", o_VALID, 1'b0);

        do_reset();
        mcnt = 16'h0;
        for (int c = 0; c < 400; c++) begin
            chk("rnd_valid", o_VALID, q.size() != 0);
            chk("rnd_ready", o_READY, q.size() < 2);
            chk("rnd_cnt", o_BEAT_CNT, mcnt);
            if (q.size() != 0) begin
                chk("rnd_top", o_BUTTERFLY_TOP, q[0].top);
                chk("rnd_bot", o_BUTTERFLY_BOTTOM, q[0].bot);
                chk("rnd_tag", o_TAG, q[0].tag);
                chk("rnd_err", o_STRIDE_ERR, q[0].err);
            end
            i_VALID   = ($urandom_range(0, 3) != 0);
            i_READY   = ($urandom_range(0, 2) != 0);
            i_CNT_CLR = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4: i_STRIDE = SW'($urandom_range(0, 4));
                5:             i_STRIDE = 10'd8;
                6:             i_STRIDE = SW'(1 << $urandom_range(3, 9));
                default:       i_STRIDE = 10'd3;
            endcase
            i_READ_OUTPUT1 = {$urandom, $urandom, $urandom, $urandom};
            i_READ_OUTPUT2 = {$urandom, $urandom, $urandom, $urandom};
            i_TAG = TW'($urandom);
            acc  = i_VALID && o_READY;
            fire = o_VALID && i_READY;
            nb   = model(i_STRIDE, i_READ_OUTPUT1, i_READ_OUTPUT2, i_TAG);
            @(posedge clk);
            if (fire) void'(q.pop_front());
            if (acc) q.push_back(nb);
            if (i_CNT_CLR) mcnt = 16'h0;
            else if (acc && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
            #1;
        end
        i_VALID   = 1'b0;
        i_CNT_CLR = 1'b0;

        do_reset();
        next_tag   = 1;
        stall      = 0;
        first_seen = 1'b0;
        dropped    = 1'b0;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            i_VALID = (next_tag <= 5);
            i_TAG   = TW'(next_tag);
            if (o_VALID && !first_seen) begin
                first_seen = 1'b1;
                stall = 3;
            end
            i_READY = (stall == 0);
            if (stall > 0) stall--;
            if (!o_READY) dropped = 1'b1;
            acc     = i_VALID && o_READY;
            fire    = o_VALID && i_READY;
            cur_tag = o_TAG;
            @(posedge clk);
            if (acc) next_tag++;
            if (fire) got.push_back(cur_tag);
            #1;
        end
        i_VALID = 1'b0;
        i_READY = 1'b1;
        chk("bp_ready_dropped", dropped, 1'b1);
        chk("bp_count", got.size(), 5);
        for (int i = 0; i < got.size(); i++)
            chk("bp_order", got[i], TW'(i + 1));

        do_reset();
        i_READY  = 1'b0;
        i_VALID  = 1'b1;
        i_STRIDE = 10'd1;
        i_TAG    = 8'h31;
        @(posedge clk);
        #1 i_TAG = 8'h32;
        @(posedge clk);
        #1 i_VALID = 1'b0;
        chk("mid_valid", o_VALID, 1'b1);
        chk("mid_skid_full", o_READY, 1'b0);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", o_VALID, 1'b0);
        chk("mid_rst_ready", o_READY, 1'b0);
        chk("mid_rst_cnt", o_BEAT_CNT, 16'h0);
        chk("mid_rst_top", o_BUTTERFLY_TOP, '0);
        chk("mid_rst_tag", o_TAG, '0);
        @(posedge clk);
        #1 resetn = 1'b1;
        i_READY = 1'b1;
        @(posedge clk);
        #1;
        chk("post_ready", o_READY, 1'b1);
        chk("post_empty", o_VALID, 1'b0);
        i_VALID  = 1'b1;
        i_STRIDE = 10'd2;
        i_TAG    = 8'h77;
        i_READ_OUTPUT1 = R1;
        i_READ_OUTPUT2 = R2;
        @(posedge clk);
        #1 i_VALID = 1'b0;
        chk("post_valid", o_VALID, 1'b1);
        chk("post_top", o_BUTTERFLY_TOP, T2);
        chk("post_bot", o_BUTTERFLY_BOTTOM, B2);
        chk("post_tag", o_TAG, 8'h77);
        @(posedge clk);
        #1;
        chk("post_alone", o_VALID, 1'b0);
        chk("post_cnt", o_BEAT_CNT, 16'h1);

        do_reset();
        i_VALID  = 1'b1;
        i_READY  = 1'b1;
        i_STRIDE = 10'd1;
        repeat (65536) @(posedge clk);
        #1;
        chk("sat_cnt", o_BEAT_CNT, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("sat_hold", o_BEAT_CNT, 16'hFFFF);
        i_CNT_CLR = 1'b1;
        @(posedge clk);
        #1 i_CNT_CLR = 1'b0;
        chk("clr_prio", o_BEAT_CNT, 16'h0);
        @(posedge clk);
        #1 i_VALID = 1'b0;
        chk("clr_resume", o_BEAT_CNT, 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
